// File: rtl/mem_squash_pkg.sv
// Shared encodings and width helper for the squashable memory response controller.
package mem_squash_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic int cnt_width(input int max_inflight);
    return $clog2(max_inflight + 1);
  endfunction

endpackage

// File: rtl/mem_inflight_counter.sv
// Saturating up/down counter with parallel load; decrement never wraps below zero.
module mem_inflight_counter
  import mem_squash_pkg::*;
#(
  parameter int MAX = 4,
  parameter int W   = cnt_width(MAX)
) (
  input  logic         clk,
  input  logic         rst_n_i,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] cnt_d_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         dec_ok;

  assign dec_ok = dec_i && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else begin
      unique case ({inc_i, dec_ok})
        2'b10:   if (cnt_q < W'(MAX)) cnt_d = cnt_q + W'(1);
        2'b01:   cnt_d = cnt_q - W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o   = cnt_q;
  assign cnt_d_o = cnt_d;

endmodule

// File: rtl/mem_squash_ctrl.sv
// Tracks outstanding memory requests and silently drops responses belonging to
// requests that were squashed, passing all others straight through.
module mem_squash_ctrl
  import mem_squash_pkg::*;
#(
  parameter int p_msg_nbits    = 32,
  parameter int p_max_inflight = 4,
  localparam int CW            = cnt_width(p_max_inflight)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   proc_req_val,
  output logic                   proc_req_rdy,
  output logic                   mem_req_val,
  input  logic                   mem_req_rdy,
  input  logic [p_msg_nbits-1:0] mem_resp_msg,
  input  logic                   mem_resp_val,
  output logic                   mem_resp_rdy,
  output logic [p_msg_nbits-1:0] proc_resp_msg,
  output logic                   proc_resp_val,
  input  logic                   proc_resp_rdy,
  input  logic                   squash,
  output logic [CW-1:0]          inflight,
  output logic                   draining,
  output logic                   err
);

  logic [CW-1:0] i_q, i_d;
  logic [CW-1:0] d_q, d_d;
  logic          err_q, err_d;
  state_e        state_q, state_d;

  logic can_req, drop, req_go, resp_go, resp_dec_i, resp_dec_d;

  // Squash blocks new requests so the drop count captured this cycle stays exact.
  assign can_req = !squash && (i_q < CW'(p_max_inflight));
  assign drop    = (d_q != '0) || squash;

  assign mem_req_val   = reset && proc_req_val && can_req;
  assign proc_req_rdy  = reset && mem_req_rdy && can_req;
  assign proc_resp_val = reset && !drop && mem_resp_val;
  assign mem_resp_rdy  = reset && (drop || proc_resp_rdy);
  assign proc_resp_msg = mem_resp_msg;

  assign req_go     = mem_req_val && mem_req_rdy;
  assign resp_go    = mem_resp_val && mem_resp_rdy;
  assign resp_dec_i = resp_go && (i_q != '0);
  assign resp_dec_d = resp_go && (d_q != '0);

  mem_inflight_counter #(
    .MAX (p_max_inflight),
    .W   (CW)
  ) u_inflight (
    .clk        (clk),
    .rst_n_i    (reset),
    .inc_i      (req_go),
    .dec_i      (resp_go),
    .load_i     (1'b0),
    .load_val_i ('0),
    .cnt_o      (i_q),
    .cnt_d_o    (i_d)
  );

  // A response in the squash cycle retires against I only, so it is excluded from D'.
  always_comb begin
    d_d = d_q - CW'(resp_dec_d);
    if (squash) d_d = i_q - CW'(resp_dec_i);
  end

  assign err_d = err_q || (resp_go && (i_q == '0));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (i_d != '0) state_d = (d_d != '0) ? ST_DRAIN : ST_BUSY;
      ST_BUSY,
      ST_DRAIN: begin
        if (i_d == '0)      state_d = ST_IDLE;
        else if (d_d != '0) state_d = ST_DRAIN;
        else                state_d = ST_BUSY;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      d_q     <= '0;
      err_q   <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      d_q     <= d_d;
      err_q   <= err_d;
      state_q <= state_d;
    end
  end

  assign inflight = i_q;
  assign draining = (state_q == ST_DRAIN);
  assign err      = err_q;

endmodule
